fp_seq_ctrl: RTL and testbench
==============================

Name: fp_seq_ctrl

Overview:
Multi-cycle successor to the single-cycle RV32F control unit.
- Decodes the OP-FP instruction fields into an FP ALU operation code and an add/sub select.
- Sequences variable-latency FP operations (FMUL, FDIV, FSQRT) through a small FSM and down-counter.
- Stalls the integer pipeline and defers fp_RegWrite until the operation's fixed latency has elapsed.
- Sits between the decode stage and the FP datapath; the integer main decoder is unchanged.

Parameters:
MUL_LAT, 3, FMUL latency in cycles; legal range 2..2^CNT_W-1
DIV_LAT, 12, FDIV latency in cycles; same range
SQRT_LAT, 16, FSQRT latency in cycles; same range
CNT_W, 5, latency counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
instr_valid  in  1  decode stage holds a valid instruction
opcode  in  7  instruction opcode
funct5  in  5  instr[31:27]
funct3  in  3  instr[14:12]
flush  in  1  abort the in-flight operation with no writeback
stall  out  1  hold the pipeline (PC and decode inputs held stable)
fp_start  out  1  one-cycle start pulse to the multi-cycle FP unit
fp_op  out  4  FP ALU operation code
add_sub  out  1  1 = subtract (only when fp_op==ADD)
fp_RegWrite  out  1  FP register-file write enable
busy  out  1  FSM not in IDLE
illegal  out  1  OP-FP with an unknown funct5

Behaviour:
Reset state:
- Async rst forces state IDLE and counter 0.
- stall, fp_start, fp_RegWrite, busy and illegal are 0; fp_op register 0.
- Reset mid-operation abandons the operation silently.

Decode (combinational, shared package function):
- Applies only when opcode==7'b1010011.
- funct5 mapping: 00000/00001 -> ADD(0); 00010 -> MUL(1); 00011 -> DIV(2); 01011 -> SQRT(3); 00100 -> SGNJ(4); 00101 -> MINMAX(5); 10100 -> CMP(6); 11000/11010/11100/11110 -> CVTMV(7).
- funct5 11100 with funct3==001 -> CLASS(8) instead of CVTMV.
- Any other funct5 -> ILL(15).
- add_sub = (fp_op==ADD) & funct5[0].

FSM states: IDLE, EXEC, WB.

IDLE:
- Condition for the actions below: instr_valid & OP-FP.
- Single-cycle op: fp_RegWrite=1 in the same cycle; stall=0; fp_op = decoded value (combinational path); state stays IDLE.
- MUL/DIV/SQRT: stall=1 and fp_start=1 this cycle (cycle T); latch fp_op; cnt <= LAT-1; next state EXEC.
- ILL: illegal=1 for that cycle; no write; no stall.
- Non-FP instruction: all outputs 0.

EXEC:
- stall=1; busy=1; fp_op held at the latched value; inputs ignored.
- If cnt==1, next state WB; otherwise cnt decrements by 1.
- Occupies cycles T+1 .. T+LAT-1.

WB (cycle T+LAT):
- fp_RegWrite=1; stall=0; fp_op still latched.
- The instruction retires at this clock edge; inputs are ignored.
- Next state IDLE.

Timing summary: a multi-cycle op holds stall high for exactly LAT cycles (T .. T+LAT-1). A new instruction can be accepted at T+LAT+1.

flush:
- Highest priority after rst.
- In any state: next state IDLE, and fp_RegWrite/fp_start/stall are forced to 0 that cycle.
- flush in the same cycle as an IDLE accept: no start is issued.

busy = (state != IDLE).

All outputs not listed for a state are 0.

Decomposition:
Package fp_ctrl_pkg holds:
- The OP_FP opcode constant.
- The funct5 constants.
- The 4-bit fp_op enum (ADD..CLASS, ILL=15).
- The state enum.
- The function fp_decode(funct5, funct3) returning fp_op.

Optional sub-module fp_lat_counter (load/decrement/terminal-count) handles the counter; the FSM stays in fp_seq_ctrl.

Test Plan:
1. Reset, then FADD (funct5=00000) valid -> same cycle fp_op=0, add_sub=0, fp_RegWrite=1, stall=0; FSUB (00001) -> add_sub=1.
2. FDIV (00011) with DIV_LAT=12 accepted at cycle T -> fp_start=1 only at T; stall=1 for T..T+11; fp_RegWrite=1 only at T+12; fp_op=2 throughout.
3. FSQRT with SQRT_LAT=2 (minimum latency) -> stall at T and T+1; WB at T+2; a back-to-back FMUL presented at T+3 is accepted (fp_start=1).
4. FDIV with flush asserted at T+5 -> state IDLE at T+6; fp_RegWrite is never asserted; busy=0 from T+6.
5. rst asserted asynchronously mid-EXEC of FMUL -> all outputs 0 immediately; after release, FADD executes normally.
6. funct5=11111 OP-FP -> illegal=1, fp_op=15, fp_RegWrite=0, stall=0; opcode 0110011 (integer) -> all outputs 0; FCLASS (11100, funct3=001) -> fp_op=8.

Source files
------------

// File: rtl/fp_ctrl_pkg.sv
// fp_ctrl_pkg: shared OP-FP constants, enums and the funct5/funct3 decoder
package fp_ctrl_pkg;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [4:0] F5_ADD    = 5'b00000;
  localparam logic [4:0] F5_SUB    = 5'b00001;
  localparam logic [4:0] F5_MUL    = 5'b00010;
  localparam logic [4:0] F5_DIV    = 5'b00011;
  localparam logic [4:0] F5_SQRT   = 5'b01011;
  localparam logic [4:0] F5_SGNJ   = 5'b00100;
  localparam logic [4:0] F5_MINMAX = 5'b00101;
  localparam logic [4:0] F5_CMP    = 5'b10100;
  localparam logic [4:0] F5_CVT0   = 5'b11000;
  localparam logic [4:0] F5_CVT1   = 5'b11010;
  localparam logic [4:0] F5_MVX    = 5'b11100;
  localparam logic [4:0] F5_CVT3   = 5'b11110;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_MUL = 4'd1, OP_DIV = 4'd2, OP_SQRT = 4'd3, OP_SGNJ = 4'd4,
    OP_MINMAX = 4'd5, OP_CMP = 4'd6, OP_CVTMV = 4'd7, OP_CLASS = 4'd8, OP_ILL = 4'd15
  } fp_op_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;
  function automatic fp_op_e fp_decode(input logic [4:0] f5, input logic [2:0] f3);
    case (f5)
      F5_ADD, F5_SUB:             return OP_ADD;
      F5_MUL:                     return OP_MUL;
      F5_DIV:                     return OP_DIV;
      F5_SQRT:                    return OP_SQRT;
      F5_SGNJ:                    return OP_SGNJ;
      F5_MINMAX:                  return OP_MINMAX;
      F5_CMP:                     return OP_CMP;
      F5_CVT0, F5_CVT1, F5_CVT3:  return OP_CVTMV;
      F5_MVX:                     return f3 == 3'b001 ? OP_CLASS : OP_CVTMV;
      default:                    return OP_ILL;
    endcase
  endfunction
endpackage

// File: rtl/fp_lat_counter.sv
// fp_lat_counter: loadable latency down-counter with terminal count at 1
// Ports: clk/rst (async high), i_load + i_load_val loads, i_dec decrements, o_tc flags count==1.
module fp_lat_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec) r_cnt <= r_cnt - CNT_W'(1);
  assign o_tc = r_cnt == CNT_W'(1);
endmodule

// File: rtl/fp_seq_ctrl.sv
// fp_seq_ctrl: OP-FP decode and multi-cycle FMUL/FDIV/FSQRT sequencer
// Ports: instr_valid/opcode/funct5/funct3 from decode, flush aborts in-flight op;
// stall holds the pipeline, fp_start pulses the FP unit, fp_op/add_sub select the ALU op,
// fp_RegWrite enables FP writeback, busy = not idle, illegal flags unknown OP-FP funct5.
module fp_seq_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [6:0] opcode,
  input  logic [4:0] funct5,
  input  logic [2:0] funct3,
  input  logic       flush,
  output logic       stall,
  output logic       fp_start,
  output logic [3:0] fp_op,
  output logic       add_sub,
  output logic       fp_RegWrite,
  output logic       busy,
  output logic       illegal
);
  state_e           r_state, w_next;
  fp_op_e           r_op, w_dec;
  logic             w_fp, w_multi, w_load, w_dec_en, w_tc;
  logic [CNT_W-1:0] w_lat;
  assign w_dec   = fp_decode(funct5, funct3);
  assign w_fp    = instr_valid && opcode == OP_FP;
  assign w_multi = w_dec == OP_MUL || w_dec == OP_DIV || w_dec == OP_SQRT;
  // Counter is loaded with LAT-1 so EXEC spans T+1..T+LAT-1 and WB lands on T+LAT.
  assign w_lat   = w_dec == OP_MUL ? CNT_W'(MUL_LAT - 1) :
                   w_dec == OP_DIV ? CNT_W'(DIV_LAT - 1) : CNT_W'(SQRT_LAT - 1);
  assign busy    = r_state != S_IDLE;
  assign add_sub = r_state == S_IDLE && w_fp && w_dec == OP_ADD && funct5[0];
  fp_lat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_lat),
    .i_dec      (w_dec_en),
    .o_tc       (w_tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
    end else begin
      r_state <= w_next;
      if (w_load) r_op <= w_dec;
    end
  always_comb begin
    w_next      = r_state;
    stall       = 1'b0;
    fp_start    = 1'b0;
    fp_RegWrite = 1'b0;
    illegal     = 1'b0;
    fp_op       = '0;
    w_load      = 1'b0;
    w_dec_en    = 1'b0;
    case (r_state)
      S_IDLE: if (w_fp) begin
        fp_op   = w_dec;
        illegal = w_dec == OP_ILL;
        if (w_multi) begin
          stall    = 1'b1;
          fp_start = 1'b1;
          w_load   = 1'b1;
          w_next   = S_EXEC;
        end else fp_RegWrite = w_dec != OP_ILL;
      end
      S_EXEC: begin
        stall    = 1'b1;
        fp_op    = r_op;
        w_next   = w_tc ? S_WB : S_EXEC;
        w_dec_en = !w_tc;
      end
      S_WB: begin
        fp_RegWrite = 1'b1;
        fp_op       = r_op;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Flush kills any start, stall and writeback this cycle; decode outputs stay visible.
    if (flush) begin
      w_next      = S_IDLE;
      stall       = 1'b0;
      fp_start    = 1'b0;
      fp_RegWrite = 1'b0;
      w_load      = 1'b0;
      w_dec_en    = 1'b0;
    end
  end
endmodule

// File: tb/tb_fp_seq_ctrl.sv
// tb_fp_seq_ctrl: scoreboard bench for fp_seq_ctrl against a cycle-index reference model
module tb_fp_seq_ctrl;
  localparam int MUL_L = 3, DIV_L = 12, SQRT_L = 2;
  localparam logic [6:0] OPFP = 7'b1010011, OPINT = 7'b0110011;
  logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, flush = 1'b0;
  logic [6:0] opcode = '0;
  logic [4:0] funct5 = '0;
  logic [2:0] funct3 = '0;
  logic stall, fp_start, add_sub, fp_RegWrite, busy, illegal;
  logic [3:0] fp_op;
  logic [9:0] w_out;
  typedef struct {int cy; logic [9:0] v;} exp_t;
  exp_t q[$];
  int n_tests = 0, n_fail = 0;
  bit in_op = 0;
  int wb_at = 0, mop = 0, cyc_n = 0;
  fp_seq_ctrl #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .SQRT_LAT(SQRT_L), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct5(funct5),
    .funct3(funct3), .flush(flush), .stall(stall), .fp_start(fp_start), .fp_op(fp_op),
    .add_sub(add_sub), .fp_RegWrite(fp_RegWrite), .busy(busy), .illegal(illegal)
  );
  assign w_out = {stall, fp_start, fp_op, add_sub, fp_RegWrite, busy, illegal};
  always #5 clk = ~clk;
  function automatic int ref_op(input logic [4:0] f5, input logic [2:0] f3);
    case (f5)
      5'b00000, 5'b00001: return 0;
      5'b00010: return 1;
      5'b00011: return 2;
      5'b01011: return 3;
      5'b00100: return 4;
      5'b00101: return 5;
      5'b10100: return 6;
      5'b11000, 5'b11010, 5'b11110: return 7;
      5'b11100: return f3 == 3'b001 ? 8 : 7;
      default: return 15;
    endcase
  endfunction
  function automatic int lat_of(input int op);
    return op == 1 ? MUL_L : op == 2 ? DIV_L : op == 3 ? SQRT_L : 0;
  endfunction
  task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: outputs %b, required %b (stall,start,op[4],add_sub,we,busy,ill)", name, got, want);
    end
  endtask
  task automatic cyc(input bit v, input logic [6:0] oc, input logic [4:0] f5, input logic [2:0] f3, input bit fl);
    logic st, sa, as, rw, bs, il;
    int eo, lat;
    exp_t e;
    @(posedge clk);
    #1;
    instr_valid = v; opcode = oc; funct5 = f5; funct3 = f3; flush = fl;
    st = 0; sa = 0; as = 0; rw = 0; il = 0; eo = 0;
    bs = in_op;
    if (in_op) begin
      eo = mop;
      if (cyc_n < wb_at) st = 1;
      else begin
        rw = 1;
        in_op = 0;
      end
    end else if (v && oc == OPFP) begin
      eo = ref_op(f5, f3);
      lat = lat_of(eo);
      il = eo == 15;
      as = eo == 0 && f5[0];
      if (lat > 0) begin
        st = 1; sa = 1; in_op = 1; wb_at = cyc_n + lat; mop = eo;
      end else rw = !il;
    end
    if (fl) begin
      st = 0; sa = 0; rw = 0; in_op = 0;
    end
    e.cy = cyc_n;
    e.v = {st, sa, eo[3:0], as, rw, bs, il};
    q.push_back(e);
    cyc_n++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 7'd0, 5'd0, 3'd0, 0);
  endtask
  task automatic async_reset();
    @(posedge clk);
    #2;
    instr_valid = 0; flush = 0;
    rst = 1;
    #1;
    check("async_rst", w_out, 10'b0);
    @(negedge clk);
    #1;
    check("rst_hold", w_out, 10'b0);
    rst = 0;
    in_op = 0;
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check($sformatf("cyc%0d", e.cy), w_out, e.v);
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end
  initial begin
    logic [4:0] f5_tab [14];
    f5_tab = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011, 5'b00100, 5'b00101,
               5'b10100, 5'b11000, 5'b11010, 5'b11100, 5'b11110, 5'b11111, 5'b01100};
    #2;
    check("reset_state", w_out, 10'b0);
    @(negedge clk);
    rst = 0;
    cyc(1, OPFP, 5'b00000, 3'd0, 0);
    cyc(1, OPFP, 5'b00001, 3'd0, 0);
    cyc(1, OPFP, 5'b00011, 3'd0, 0);
    idle(13);
    cyc(1, OPFP, 5'b01011, 3'd0, 0);
    idle(2);
    cyc(1, OPFP, 5'b00010, 3'd0, 0);
    idle(4);
    cyc(1, OPFP, 5'b00011, 3'd0, 0);
    idle(4);
    cyc(0, 7'd0, 5'd0, 3'd0, 1);
    idle(3);
    cyc(1, OPFP, 5'b00010, 3'd0, 1);
    idle(1);
    cyc(1, OPFP, 5'b00010, 3'd0, 0);
    idle(1);
    async_reset();
    cyc(1, OPFP, 5'b00000, 3'd0, 0);
    cyc(1, OPFP, 5'b11111, 3'd0, 0);
    cyc(1, OPINT, 5'b00000, 3'd0, 0);
    cyc(1, OPFP, 5'b11100, 3'b001, 0);
    cyc(1, OPFP, 5'b11100, 3'b000, 0);
    cyc(0, OPFP, 5'b00000, 3'd0, 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 9) < 8 ? OPFP : OPINT,
          f5_tab[$urandom_range(0, 13)], 3'($urandom_range(0, 7)), $urandom_range(0, 24) == 0);
    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
